sw_pe_affine_cfg: RTL and testbench

Next-generation Smith-Waterman systolic processing element with affine gap penalty. One PE holds one query symbol and processes one reference symbol per valid beat. Symbol width, score width and position-counter width are parameters; scoring is runtime-loaded. The PE adds a traceback-direction output, saturating arithmetic, bubble (stall) support and optional per-row local-maximum tracking. It chains PE-to-PE in the systolic array, with the query loaded through the same store chain.

---
 rtl/sw_pkg.sv | 42 ++++
 rtl/sw_max_sel.sv | 37 +++
 rtl/sw_pe_affine_cfg.sv | 169 ++++++++++++++++
 tb/tb_sw_pe_affine_cfg.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman affine-gap PE.
// Holds the traceback direction codes, the NEG_INF floor as a function of
// the score width, and the saturating add/sub helpers. Helpers work on int
// and take the score width as an argument so any W up to 30 bits is covered.
package sw_pkg;

  typedef enum logic [1:0] {
    DIR_ZERO = 2'b00,
    DIR_DIAG = 2'b01,
    DIR_E    = 2'b10,
    DIR_F    = 2'b11
  } dir_e;

  // Lower clamp: -(2^(w-2)), leaving headroom below so gap penalties never wrap.
  function automatic int neg_inf(input int unsigned w);
    return -(1 << (w - 32'd2));
  endfunction

  // Upper clamp: 2^(w-1)-1.
  function automatic int pos_max(input int unsigned w);
    return (1 << (w - 32'd1)) - 1;
  endfunction

  function automatic int sat_clip(input int x, input int unsigned w);
    if (x > pos_max(w)) return pos_max(w);
    if (x < neg_inf(w)) return neg_inf(w);
    return x;
  endfunction

  function automatic int sat_add(input int a, input int b, input int unsigned w);
    return sat_clip(a + b, w);
  endfunction

  function automatic int sat_sub(input int a, input int b, input int unsigned w);
    return sat_clip(a - b, w);
  endfunction

  function automatic int smax2(input int a, input int b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_max_sel.sv
// Combinational 4-way signed max of {D, E, F, 0} with traceback code.
// Ties resolve D > E > F > zero, so DIR_ZERO appears only when every
// candidate is strictly negative.
//   d_i, e_i, f_i : candidate scores
//   v_c           : selected cell score
//   dir_c         : traceback direction of the winner
module sw_max_sel
  import sw_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic signed [W-1:0] d_i,
  input  logic signed [W-1:0] e_i,
  input  logic signed [W-1:0] f_i,
  output logic signed [W-1:0] v_c,
  output dir_e                dir_c
);

  // Strict > against the running winner keeps the earlier (higher priority) candidate on ties.
  always_comb begin
    v_c   = d_i;
    dir_c = DIR_DIAG;
    if (e_i > v_c) begin
      v_c   = e_i;
      dir_c = DIR_E;
    end
    if (f_i > v_c) begin
      v_c   = f_i;
      dir_c = DIR_F;
    end
    if (v_c[W-1]) begin
      v_c   = '0;
      dir_c = DIR_ZERO;
    end
  end

endmodule

// File: rtl/sw_pe_affine_cfg.sv
// Smith-Waterman systolic PE with affine gaps, runtime scoring and bubbles.
// One query symbol is held in S_reg; one reference symbol is scored per
// valid beat. All outputs are registered (1-cycle latency).
// Optional build macro SW_PE_LOCAL_MAX_EN adds per-row max tracking ports:
//   max_out / max_pos_out / max_valid_out.
// Ports:
//   clk, rst (sync, active-low)
//   cfg_we + cfg_match/mismatch/gap_open/gap_ext : scoring load
//   S_in/store_S_in -> S_out/store_S_out          : query store chain
//   T_in/valid_in/first_in/last_in -> *_out       : reference stream
//   V_in/F_in                                     : upstream V(i-1,j), F(i-1,j)
//   V_out/E_out/F_out/dir_out                     : this cell's scores and traceback
module sw_pe_affine_cfg
  import sw_pkg::*;
#(
  parameter int unsigned W     = 10,
  parameter int unsigned SYM_W = 2,
  parameter int unsigned POS_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [W-1:0]        cfg_match,
  input  logic [W-1:0]        cfg_mismatch,
  input  logic [W-1:0]        cfg_gap_open,
  input  logic [W-1:0]        cfg_gap_ext,
  input  logic [SYM_W-1:0]    S_in,
  input  logic                store_S_in,
  output logic [SYM_W-1:0]    S_out,
  output logic                store_S_out,
  input  logic [SYM_W-1:0]    T_in,
  input  logic                valid_in,
  input  logic                first_in,
  input  logic                last_in,
  input  logic signed [W-1:0] V_in,
  input  logic signed [W-1:0] F_in,
  output logic signed [W-1:0] V_out,
  output logic signed [W-1:0] E_out,
  output logic signed [W-1:0] F_out,
  output logic [SYM_W-1:0]    T_out,
  output logic                valid_out,
  output logic                first_out,
  output logic                last_out,
  output logic [1:0]          dir_out
`ifdef SW_PE_LOCAL_MAX_EN
  ,
  output logic signed [W-1:0] max_out,
  output logic [POS_W-1:0]    max_pos_out,
  output logic                max_valid_out
`endif
);

  localparam logic signed [W-1:0] NEG_INF = W'(neg_inf(W));

  logic [SYM_W-1:0]    s_q;
  logic [W-1:0]        match_q, mismatch_q, go_q, ge_q;
  logic signed [W-1:0] v_diag_q, v_left_q, e_left_q;

  int                  vdiag_c, vleft_c, eleft_c, sub_c;
  logic signed [W-1:0] d_c, e_c, f_c, v_c;
  dir_e                dir_c;

  // Cell recurrence; a first-column beat sees an empty left/diagonal neighbourhood.
  always_comb begin
    vdiag_c = first_in ? 0 : int'(v_diag_q);
    vleft_c = first_in ? 0 : int'(v_left_q);
    eleft_c = first_in ? int'(NEG_INF) : int'(e_left_q);
    sub_c   = (T_in == s_q) ? int'(match_q) : -int'(mismatch_q);
    d_c     = W'(sat_add(vdiag_c, sub_c, W));
    e_c     = W'(smax2(sat_sub(vleft_c, int'(go_q), W),
                       sat_sub(eleft_c, int'(ge_q), W)));
    f_c     = W'(smax2(sat_sub(int'(V_in), int'(go_q), W),
                       sat_sub(int'(F_in), int'(ge_q), W)));
  end

  sw_max_sel #(.W(W)) u_max_sel (
    .d_i   (d_c),
    .e_i   (e_c),
    .f_i   (f_c),
    .v_c   (v_c),
    .dir_c (dir_c)
  );

  // Config/query loads and the scored beat share the edge, so a same-cycle beat uses old values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q         <= '0;
      match_q     <= '0;
      mismatch_q  <= '0;
      go_q        <= '0;
      ge_q        <= '0;
      v_diag_q    <= '0;
      v_left_q    <= '0;
      e_left_q    <= NEG_INF;
      V_out       <= '0;
      E_out       <= '0;
      F_out       <= '0;
      dir_out     <= '0;
      T_out       <= '0;
      valid_out   <= 1'b0;
      first_out   <= 1'b0;
      last_out    <= 1'b0;
      S_out       <= '0;
      store_S_out <= 1'b0;
    end else begin
      T_out       <= T_in;
      valid_out   <= valid_in;
      first_out   <= first_in;
      last_out    <= last_in;
      S_out       <= S_in;
      store_S_out <= store_S_in;
      if (store_S_in) s_q <= S_in;
      if (cfg_we) begin
        match_q    <= cfg_match;
        mismatch_q <= cfg_mismatch;
        go_q       <= cfg_gap_open;
        ge_q       <= cfg_gap_ext;
      end
      if (valid_in) begin
        v_diag_q <= V_in;
        v_left_q <= v_c;
        e_left_q <= e_c;
        V_out    <= v_c;
        E_out    <= e_c;
        F_out    <= f_c;
        dir_out  <= dir_c;
      end
    end
  end

`ifdef SW_PE_LOCAL_MAX_EN
  logic [POS_W-1:0]    col_q, col_c, pos_q, run_pos_c;
  logic signed [W-1:0] max_q, run_max_c;

  // Running row maximum including the current beat; strict > keeps the earliest column on ties.
  always_comb begin
    col_c     = first_in ? '0 : col_q + POS_W'(1);
    run_max_c = max_q;
    run_pos_c = pos_q;
    if (first_in || (v_c > max_q)) begin
      run_max_c = v_c;
      run_pos_c = col_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q         <= '0;
      max_q         <= '0;
      pos_q         <= '0;
      max_out       <= '0;
      max_pos_out   <= '0;
      max_valid_out <= 1'b0;
    end else begin
      max_valid_out <= valid_in & last_in;
      if (valid_in) begin
        col_q <= col_c;
        max_q <= run_max_c;
        pos_q <= run_pos_c;
        if (last_in) begin
          max_out     <= run_max_c;
          max_pos_out <= run_pos_c;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sw_pe_affine_cfg.sv
// Scoreboard bench for sw_pe_affine_cfg: the driver pushes expected cell
// results per valid beat, a monitor pops and compares on valid_out.
module tb_sw_pe_affine_cfg;

  localparam int W_T    = 10;
  localparam int POSMAX = 511;
  localparam int NEGINF = -256;

  typedef int row_t [8];
  typedef struct { int v; int e; int f; int dir; } exp_t;
  typedef struct { int mx; int pos; } mexp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [W_T-1:0]        cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_ext;
  logic [1:0]            S_in, S_out, T_in, T_out, dir_out;
  logic                  store_S_in, store_S_out;
  logic                  valid_in, first_in, last_in;
  logic                  valid_out, first_out, last_out;
  logic signed [W_T-1:0] V_in, F_in, V_out, E_out, F_out;
`ifdef SW_PE_LOCAL_MAX_EN
  logic signed [W_T-1:0] max_out;
  logic [15:0]           max_pos_out;
  logic                  max_valid_out;
`endif

  sw_pe_affine_cfg #(.W(10), .SYM_W(2), .POS_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_match    (cfg_match),
    .cfg_mismatch (cfg_mismatch),
    .cfg_gap_open (cfg_gap_open),
    .cfg_gap_ext  (cfg_gap_ext),
    .S_in         (S_in),
    .store_S_in   (store_S_in),
    .S_out        (S_out),
    .store_S_out  (store_S_out),
    .T_in         (T_in),
    .valid_in     (valid_in),
    .first_in     (first_in),
    .last_in      (last_in),
    .V_in         (V_in),
    .F_in         (F_in),
    .V_out        (V_out),
    .E_out        (E_out),
    .F_out        (F_out),
    .T_out        (T_out),
    .valid_out    (valid_out),
    .first_out    (first_out),
    .last_out     (last_out),
    .dir_out      (dir_out)
`ifdef SW_PE_LOCAL_MAX_EN
    ,
    .max_out       (max_out),
    .max_pos_out   (max_pos_out),
    .max_valid_out (max_valid_out)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  exp_t  sb[$];
  mexp_t mq[$];

  // Reference model state
  int m_s, m_match, m_mm, m_go, m_ge;
  int m_vdiag, m_vleft, m_eleft;
  int m_max, m_pos, m_col;
  bit cfg_pend;
  int p_match;

  logic [1:0] ref_t [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
  row_t tab1 = '{10, 8, 10, 8, 10, 8, 7, 10};
  row_t tab2 = '{0, 10, 8, 7, 6, 10, 8, 7};
  row_t tab3 = '{8, 8, 8, 8, 8, 8, 20, 18};
  row_t tab5 = '{498, 498, 498, 498, 498, 498, 511, 509};

  function automatic int clip(input int x);
    if (x > POSMAX) return POSMAX;
    if (x < NEGINF) return NEGINF;
    return x;
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_s = 0; m_match = 0; m_mm = 0; m_go = 0; m_ge = 0;
    m_vdiag = 0; m_vleft = 0; m_eleft = NEGINF;
    m_max = 0; m_pos = 0; m_col = 0;
  endtask

  task automatic drive_common();
    rst        = 1'b1;
    cfg_we     = 1'b0;
    store_S_in = 1'b0;
    S_in       = 2'($urandom);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = 1'b0;
      valid_in = 1'b1;
      first_in = 1'b0;
      last_in  = 1'b1;
      T_in     = 2'($urandom);
    end
    model_reset();
  endtask

  task automatic load(input int q, input int mt, input int mm, input int go, input int ge);
    @(negedge clk);
    drive_common();
    valid_in     = 1'b0;
    first_in     = 1'b0;
    last_in      = 1'b0;
    cfg_we       = 1'b1;
    cfg_match    = 10'(mt);
    cfg_mismatch = 10'(mm);
    cfg_gap_open = 10'(go);
    cfg_gap_ext  = 10'(ge);
    store_S_in   = 1'b1;
    S_in         = 2'(q);
    m_s = q; m_match = mt; m_mm = mm; m_go = go; m_ge = ge;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_common();
      valid_in = 1'b0;
      first_in = 1'($urandom);
      last_in  = 1'($urandom);
      T_in     = 2'($urandom);
    end
  endtask

  task automatic drive_beat(input logic [1:0] t, input bit fst, input bit lst,
                            input int vin, input int fin, input int tab_v);
    int vd, vl, el, sub, d, e, f, v, dr;
    @(negedge clk);
    drive_common();
    valid_in = 1'b1;
    T_in     = t;
    first_in = fst;
    last_in  = lst;
    V_in     = 10'(vin);
    F_in     = 10'(fin);
    if (cfg_pend) begin
      cfg_we       = 1'b1;
      cfg_match    = 10'(p_match);
      cfg_mismatch = 10'(m_mm);
      cfg_gap_open = 10'(m_go);
      cfg_gap_ext  = 10'(m_ge);
    end
    vd  = fst ? 0 : m_vdiag;
    vl  = fst ? 0 : m_vleft;
    el  = fst ? NEGINF : m_eleft;
    sub = (int'(t) == m_s) ? m_match : -m_mm;
    d   = clip(vd + sub);
    e   = mx(clip(vl - m_go), clip(el - m_ge));
    f   = mx(clip(vin - m_go), clip(fin - m_ge));
    v   = mx(mx(0, d), mx(e, f));
    dr  = (v == d) ? 1 : (v == e) ? 2 : (v == f) ? 3 : 0;
    sb.push_back('{v: tab_v, e: e, f: f, dir: dr});
    m_col = fst ? 0 : m_col + 1;
    if (fst || v > m_max) begin
      m_max = v;
      m_pos = m_col;
    end
    if (lst) mq.push_back('{mx: m_max, pos: m_pos});
    m_vdiag = vin;
    m_vleft = v;
    m_eleft = e;
    if (cfg_pend) begin
      m_match  = p_match;
      cfg_pend = 1'b0;
    end
  endtask

  task automatic run_row(input int vin, input int fin, input row_t tab,
                         input int bub_after, input int cfg_col, input int rst_col);
    for (int j = 0; j < 8; j++) begin
      if (j == rst_col) begin
        do_reset(1);
        return;
      end
      if (j == cfg_col) begin
        cfg_pend = 1'b1;
        p_match  = 100;
      end
      drive_beat(ref_t[j], j == 0, j == 7, vin, fin, tab[j]);
      if (j == bub_after) idle(3);
    end
  endtask

  // Monitor: capture what was driven into this edge, check outputs just after it.
  logic       c_rst, c_vld, c_first, c_last, c_st;
  logic [1:0] c_t, c_s;
  int hv = 0, he = 0, hf = 0, hd = 0;

  always @(posedge clk) begin
    exp_t  ex;
    mexp_t mex;
    c_rst = rst; c_vld = valid_in; c_first = first_in; c_last = last_in;
    c_t = T_in; c_s = S_in; c_st = store_S_in;
    #1;
    if (!c_rst) begin
      chk("rst_V", int'(V_out), 0);
      chk("rst_E", int'(E_out), 0);
      chk("rst_F", int'(F_out), 0);
      chk("rst_dir", int'(dir_out), 0);
      chk("rst_valid", int'(valid_out), 0);
      chk("rst_T", int'(T_out), 0);
      chk("rst_first", int'(first_out), 0);
      chk("rst_last", int'(last_out), 0);
      hv = 0; he = 0; hf = 0; hd = 0;
`ifdef SW_PE_LOCAL_MAX_EN
      chk("rst_max_valid", int'(max_valid_out), 0);
      chk("rst_max", int'(max_out), 0);
`endif
    end else begin
      chk("valid_out", int'(valid_out), int'(c_vld));
      chk("T_out", int'(T_out), int'(c_t));
      chk("first_out", int'(first_out), int'(c_first));
      chk("last_out", int'(last_out), int'(c_last));
      chk("S_out", int'(S_out), int'(c_s));
      chk("store_S_out", int'(store_S_out), int'(c_st));
      if (c_vld) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          ex = sb.pop_front();
          chk("V", int'(V_out), ex.v);
          chk("E", int'(E_out), ex.e);
          chk("F", int'(F_out), ex.f);
          chk("dir", int'(dir_out), ex.dir);
          hv = ex.v; he = ex.e; hf = ex.f; hd = ex.dir;
        end
      end else begin
        chk("hold_V", int'(V_out), hv);
        chk("hold_E", int'(E_out), he);
        chk("hold_F", int'(F_out), hf);
        chk("hold_dir", int'(dir_out), hd);
      end
`ifdef SW_PE_LOCAL_MAX_EN
      chk("max_valid", int'(max_valid_out), int'(c_vld & c_last));
      if (c_vld && c_last) begin
        if (mq.size() == 0) begin
          chk("mq_underflow", mq.size(), 1);
        end else begin
          mex = mq.pop_front();
          chk("max", int'(max_out), mex.mx);
          chk("max_pos", int'(max_pos_out), mex.pos);
        end
      end
`endif
    end
  end

  initial begin
    rst = 1'b0; cfg_we = 1'b0; store_S_in = 1'b0; S_in = '0; T_in = '0;
    valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
    V_in = '0; F_in = '0;
    cfg_match = '0; cfg_mismatch = '0; cfg_gap_open = '0; cfg_gap_ext = '0;
    cfg_pend = 1'b0; p_match = 0;
    model_reset();
    do_reset(2);

    // Query A, upstream zero
    load(0, 10, 2, 2, 1);
    run_row(0, 0, tab1, -1, -1, -1);
    // Query C: column 0 scores zero
    load(1, 10, 2, 2, 1);
    run_row(0, 0, tab2, -1, -1, -1);
    // Query T with upstream V=10, F=-4: vertical gaps dominate
    load(3, 10, 2, 2, 1);
    run_row(10, -4, tab3, -1, -1, -1);
    // Bubbles after column 2
    load(0, 10, 2, 2, 1);
    run_row(0, 0, tab1, 2, -1, -1);
    // Saturation with match raised to 100 on the column 5 beat
    load(3, 10, 2, 2, 1);
    run_row(500, -4, tab5, -1, 5, -1);
    // Reset in the middle of a row, then a clean row
    load(0, 10, 2, 2, 1);
    run_row(0, 0, tab1, -1, -1, 4);
    load(0, 10, 2, 2, 1);
    run_row(0, 0, tab1, -1, -1, -1);

    idle(3);
    chk("sb_drain", sb.size(), 0);
`ifdef SW_PE_LOCAL_MAX_EN
    chk("mq_drain", mq.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
